// File: rtl/cam_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cam_pkg
// Description : Shared definitions for the camera capture path. Holds the FSM
//               state encodings of the FIFO frame drain and the default frame
//               geometry and bus widths. The pixel FIFO and the frame buffer
//               use the same geometry and widths.
// Revision    : 1.0 - initial release
// ============================================================================
package cam_pkg;

  // Default frame geometry and bus widths.
  localparam int CAM_H_RES = 160;
  localparam int CAM_V_RES = 120;
  localparam int CAM_DAT_W = 10;
  localparam int CAM_ADR_W = 16;

  // Drain FSM state encodings.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } drain_state_e;

  // Counter width able to hold 0..n-1. Never returns 0, so that a one-pixel
  // dimension still gets a legal 1-bit vector.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pix_xy_counter.sv
`default_nettype none
// ============================================================================
// Module      : pix_xy_counter
// Description : Raster position tracker for one frame. Holds the x and y pixel
//               counters and a linear address counter. The linear address
//               counter advances by one per pixel, so y*H_RES+x is never
//               multiplied out. The block also reports whether the current
//               position is the last column and/or the last line.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk       in   1      clock
//   rst_n     in   1      asynchronous active-low reset
//   clr_i     in   1      return x, y and address to 0 (takes priority)
//   inc_i     in   1      advance one pixel in raster order
//   addr_o    out  ADR_W  linear address of the current position
//   x_last_o  out  1      current x is H_RES-1
//   y_last_o  out  1      current y is V_RES-1
// ============================================================================
module pix_xy_counter
  import cam_pkg::*;
#(
  parameter int H_RES = CAM_H_RES,
  parameter int V_RES = CAM_V_RES,
  parameter int ADR_W = CAM_ADR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [ADR_W-1:0] addr_o,
  output logic             x_last_o,
  output logic             y_last_o
);

  localparam int XW = cnt_w(H_RES);
  localparam int YW = cnt_w(V_RES);

  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [ADR_W-1:0] addr_q, addr_d;

  assign x_last_o = (x_q == XW'(H_RES - 1));
  assign y_last_o = (y_q == YW'(V_RES - 1));
  assign addr_o   = addr_q;

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    addr_d = addr_q;
    if (clr_i) begin
      x_d    = '0;
      y_d    = '0;
      addr_d = '0;
    end else if (inc_i) begin
      addr_d = addr_q + 1'b1;
      if (x_last_o) begin
        x_d = '0;
        // y wraps on the last line so the counters are back at the origin
        // after a complete frame.
        y_d = y_last_o ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      addr_q <= addr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_frame_drain.sv
`default_nettype none
// ============================================================================
// Module      : fifo_frame_drain
// Description : Read-side consumer of the camera pixel FIFO. A start pulse
//               arms the capture of one frame. The block then pops exactly
//               H_RES*V_RES words from the first-word-fall-through FIFO and
//               writes each word to the linear frame-buffer write port one
//               cycle after its pop. An empty FIFO stalls the frame without
//               any timeout.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   Pclk        in   1      pixel clock (single clock domain)
//   rst         in   1      asynchronous active-low reset
//   start       in   1      1-cycle pulse that arms one frame
//   fifo_empty  in   1      FIFO empty flag
//   fifo_data   in   DAT_W  FIFO head word, valid while !fifo_empty
//   fifo_rd     out  1      FIFO pop strobe (combinational)
//   fb_we       out  1      frame-buffer write enable (registered)
//   fb_addr     out  ADR_W  frame-buffer write address (registered, holds)
//   fb_data     out  DAT_W  frame-buffer write data (registered, holds)
//   line_end    out  1      pulse alongside the write of each line's last pixel
//   busy        out  1      frame in progress
//   frame_done  out  1      pulse one cycle after the last write of a frame
//   err         out  1      sticky: start seen while a frame was active
// ============================================================================
module fifo_frame_drain
  import cam_pkg::*;
#(
  parameter int DAT_W = CAM_DAT_W,
  parameter int ADR_W = CAM_ADR_W,
  parameter int H_RES = CAM_H_RES,
  parameter int V_RES = CAM_V_RES
) (
  input  logic             Pclk,
  input  logic             rst,
  input  logic             start,
  input  logic             fifo_empty,
  input  logic [DAT_W-1:0] fifo_data,
  output logic             fifo_rd,
  output logic             fb_we,
  output logic [ADR_W-1:0] fb_addr,
  output logic [DAT_W-1:0] fb_data,
  output logic             line_end,
  output logic             busy,
  output logic             frame_done,
  output logic             err
);

  // A frame must fit inside the frame-buffer address space.
  if (longint'(H_RES) * longint'(V_RES) > (64'd1 << ADR_W)) begin : g_adr_w_check
    $error("fifo_frame_drain: H_RES*V_RES exceeds 2**ADR_W");
  end

  drain_state_e     state_q, state_d;
  logic             cnt_clr;
  logic [ADR_W-1:0] cnt_addr;
  logic             x_last;
  logic             y_last;

  logic             fb_we_q;
  logic [ADR_W-1:0] fb_addr_q;
  logic [DAT_W-1:0] fb_data_q;
  logic             line_end_q;
  logic             frame_done_q;
  logic             err_q;

  pix_xy_counter #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .ADR_W (ADR_W)
  ) u_pix_xy_counter (
    .clk      (Pclk),
    .rst_n    (rst),
    .clr_i    (cnt_clr),
    .inc_i    (fifo_rd),
    .addr_o   (cnt_addr),
    .x_last_o (x_last),
    .y_last_o (y_last)
  );

  // Next-state logic and the pop strobe.
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    fifo_rd = (state_q == ST_RUN) & ~fifo_empty;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          cnt_clr = 1'b1;
        end
      end
      ST_RUN: begin
        // Leaving RUN on the final pop stops the strobe, so no word past the
        // frame is taken from the FIFO.
        if (fifo_rd && x_last && y_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Pclk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
      line_end_q   <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      fb_we_q    <= fifo_rd;
      line_end_q <= fifo_rd & x_last;
      if (fifo_rd) begin
        fb_addr_q <= cnt_addr;
        fb_data_q <= fifo_data;
      end
      // The write of the last pixel lands in the DONE cycle. The pulse is
      // raised one cycle later, after that write has completed.
      frame_done_q <= (state_q == ST_DONE);
      // A start seen in IDLE clears err. A start seen in any other state
      // sets it.
      if (start) begin
        err_q <= (state_q != ST_IDLE);
      end
    end
  end

  assign fb_we      = fb_we_q;
  assign fb_addr    = fb_addr_q;
  assign fb_data    = fb_data_q;
  assign line_end   = line_end_q;
  assign busy       = (state_q == ST_RUN);
  assign frame_done = frame_done_q;
  assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_frame_drain.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fifo_frame_drain
// Description : Self-checking bench. Instance 0 is a 4x2 frame and instance 1
//               uses the default 160x120 geometry. Each instance is fed from
//               a queue that emulates a FWFT FIFO. Each instance is compared
//               cycle by cycle against a frame-level reference model that
//               counts pixels and derives addresses from the pixel index.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_frame_drain;

  localparam int DW = 10;
  localparam int AW = 16;
  localparam int H0 = 4;
  localparam int V0 = 2;
  localparam int H1 = 160;
  localparam int V1 = 120;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          stv  [2];
  logic          emp  [2];
  logic [DW-1:0] din  [2];
  logic          rd   [2];
  logic          we   [2];
  logic [AW-1:0] ad   [2];
  logic [DW-1:0] dt   [2];
  logic          le   [2];
  logic          bsy  [2];
  logic          fd   [2];
  logic          er   [2];

  fifo_frame_drain #(.DAT_W(DW), .ADR_W(AW), .H_RES(H0), .V_RES(V0)) dut_s (
    .Pclk(clk), .rst(rst_n), .start(stv[0]), .fifo_empty(emp[0]), .fifo_data(din[0]),
    .fifo_rd(rd[0]), .fb_we(we[0]), .fb_addr(ad[0]), .fb_data(dt[0]),
    .line_end(le[0]), .busy(bsy[0]), .frame_done(fd[0]), .err(er[0]));

  fifo_frame_drain dut_d (
    .Pclk(clk), .rst(rst_n), .start(stv[1]), .fifo_empty(emp[1]), .fifo_data(din[1]),
    .fifo_rd(rd[1]), .fb_we(we[1]), .fb_addr(ad[1]), .fb_data(dt[1]),
    .line_end(le[1]), .busy(bsy[1]), .frame_done(fd[1]), .err(er[1]));

  int checks   = 0;
  int failures = 0;

  // FIFO emulation
  logic [DW-1:0] fq0[$];
  logic [DW-1:0] fq1[$];

  function automatic int fsize(input int d);
    return (d == 0) ? fq0.size() : fq1.size();
  endfunction
  function automatic logic [DW-1:0] ffront(input int d);
    return (d == 0) ? fq0[0] : fq1[0];
  endfunction
  task automatic fpush(input int d, input logic [DW-1:0] v);
    if (d == 0) fq0.push_back(v); else fq1.push_back(v);
  endtask
  task automatic fpop(input int d);
    if (d == 0) void'(fq0.pop_front()); else void'(fq1.pop_front());
  endtask
  task automatic fclear(input int d);
    if (d == 0) fq0.delete(); else fq1.delete();
  endtask

  // Reference model: phase 0 idle, 1 capturing, 2 last write issued
  int            m_ph  [2];
  int            m_pix [2];
  bit            m_we  [2];
  bit            m_le  [2];
  bit            m_fd  [2];
  bit            m_err [2];
  logic [AW-1:0] m_ad  [2];
  logic [DW-1:0] m_dt  [2];
  int            wr_cnt[2];

  function automatic int hres(input int d); return (d == 0) ? H0 : H1; endfunction
  function automatic int vres(input int d); return (d == 0) ? V0 : V1; endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ph[d] = 0; m_pix[d] = 0; m_we[d] = 0; m_le[d] = 0;
      m_fd[d] = 0; m_err[d] = 0; m_ad[d] = '0; m_dt[d] = '0;
    end
  endtask

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s[dut%0d] observed=%0h expected=%0h t=%0t", tag, d, obs, exp, $time);
    end
  endtask

  task automatic chk_zero(input int d);
    chk("rst_fifo_rd", d, rd[d], 0);
    chk("rst_fb_we", d, we[d], 0);
    chk("rst_fb_addr", d, ad[d], 0);
    chk("rst_fb_data", d, dt[d], 0);
    chk("rst_line_end", d, le[d], 0);
    chk("rst_busy", d, bsy[d], 0);
    chk("rst_frame_done", d, fd[d], 0);
    chk("rst_err", d, er[d], 0);
  endtask

  // One clock cycle on instance d. Inputs are driven after the falling edge,
  // the pop strobe is checked before the rising edge, and the registered
  // outputs are checked 1 ns after it.
  task automatic cyc(input int d, input bit st, input bit gap, input bit feed);
    bit            exp_rd, pop_obs;
    logic [DW-1:0] head;
    int            nph;
    @(negedge clk);
    if (feed) while (fsize(d) < 4) fpush(d, DW'($urandom_range(0, 1023)));
    stv[d] = st;
    emp[d] = gap || (fsize(d) == 0);
    head   = (fsize(d) != 0) ? ffront(d) : DW'($urandom);
    din[d] = emp[d] ? DW'($urandom) : head;
    #1;
    exp_rd  = (m_ph[d] == 1) && !emp[d];
    pop_obs = rd[d];
    chk("fifo_rd", d, rd[d], exp_rd);
    @(posedge clk);
    #1;
    if (pop_obs) fpop(d);
    nph      = m_ph[d];
    m_fd[d]  = (m_ph[d] == 2);
    m_we[d]  = 0;
    m_le[d]  = 0;
    if (exp_rd) begin
      m_we[d] = 1;
      m_ad[d] = AW'(m_pix[d]);
      m_dt[d] = din[d];
      m_le[d] = (m_pix[d] % hres(d)) == hres(d) - 1;
      m_pix[d]++;
      if (m_pix[d] == hres(d) * vres(d)) nph = 2;
    end
    if (m_ph[d] == 2) nph = 0;
    if (st) begin
      if (m_ph[d] == 0) begin m_err[d] = 0; m_pix[d] = 0; nph = 1; end
      else m_err[d] = 1;
    end
    m_ph[d] = nph;
    stv[d]  = 1'b0;
    if (we[d] === 1'b1) wr_cnt[d]++;
    chk("fb_we", d, we[d], m_we[d]);
    chk("fb_addr", d, ad[d], m_ad[d]);
    chk("fb_data", d, dt[d], m_dt[d]);
    chk("line_end", d, le[d], m_le[d]);
    chk("busy", d, bsy[d], m_ph[d] == 1);
    chk("frame_done", d, fd[d], m_fd[d]);
    chk("err", d, er[d], m_err[d]);
  endtask

  // Gap modes: 0 none, 1 word every 4th cycle, 2 random 1-in-8 empties.
  function automatic bit gap_of(input int gm, input int k);
    if (gm == 1) return (k % 4) != 0;
    if (gm == 2) return $urandom_range(0, 7) == 0;
    return 1'b0;
  endfunction

  // Starts a frame and runs until frame_done. A second start is pulsed once
  // the pixel count reaches stp_at (negative = never). Stops early when the
  // model pixel count reaches stop_pix.
  task automatic run_frame(input int d, input int gm, input bit feed, input int maxc,
                           input int stp_at, input int stop_pix);
    int k;
    bit sent;
    k = 0; sent = 0; wr_cnt[d] = 0;
    cyc(d, 1'b1, gap_of(gm, k), feed);
    do begin
      k++;
      if (stop_pix >= 0 && m_pix[d] == stop_pix) return;
      if (!sent && m_ph[d] == 1 && m_pix[d] == stp_at) begin
        sent = 1;
        cyc(d, 1'b1, gap_of(gm, k), feed);
      end else begin
        cyc(d, 1'b0, gap_of(gm, k), feed);
      end
    end while (!(fd[d] === 1'b1) && k < maxc);
    chk("frame_done_seen", d, fd[d], 1);
    chk("writes_per_frame", d, wr_cnt[d], hres(d) * vres(d));
    chk("last_addr", d, ad[d], hres(d) * vres(d) - 1);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      stv[d] = 1'b0; emp[d] = 1'b1; din[d] = '0; wr_cnt[d] = 0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    chk_zero(0);
    chk_zero(1);
    rst_n = 1'b1;

    // 1: 4x2 frame, words 0..7 preloaded
    for (int i = 0; i < 8; i++) fpush(0, DW'(i));
    run_frame(0, 0, 1'b0, 40, -1, -1);
    repeat (2) cyc(0, 1'b0, 1'b0, 1'b0);

    // 2: data arriving with 3-cycle gaps
    run_frame(0, 1, 1'b1, 200, -1, -1);
    fclear(0);

    // 3: 12 random words queued for an 8-pixel frame
    for (int i = 0; i < 12; i++) fpush(0, DW'($urandom_range(0, 1023)));
    run_frame(0, 0, 1'b0, 40, -1, -1);
    repeat (3) cyc(0, 1'b0, 1'b0, 1'b0);
    chk("surplus_left", 0, fsize(0), 4);
    fclear(0);

    // 4: start while capturing, at pixel 3
    run_frame(0, 2, 1'b1, 60, 3, -1);
    chk("err_sticky", 0, er[0], 1);
    cyc(0, 1'b0, 1'b0, 1'b1);
    chk("err_held_idle", 0, er[0], 1);
    run_frame(0, 2, 1'b1, 60, -1, -1);
    chk("err_cleared", 0, er[0], 0);

    // 5: asynchronous reset mid-frame at pixel 5
    run_frame(0, 0, 1'b1, 60, -1, 5);
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero(0);
    model_reset();
    fclear(0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(0, 2, 1'b1, 60, -1, -1);

    // 6: default geometry, second start in the frame_done cycle
    run_frame(1, 2, 1'b1, 30000, -1, -1);
    run_frame(1, 2, 1'b1, 30000, -1, -1);
    cyc(1, 1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
